// File: rtl/iommu_pkg.sv
// Shared types for the IOMMU translation block: fault codes, permission bit
// positions and the default-width response record.
package iommu_pkg;

    // Fault code carried with every response
    typedef enum logic [1:0] {
        IOMMU_FAULT_NONE = 2'd0,
        IOMMU_FAULT_MISS = 2'd1,
        IOMMU_FAULT_PERM = 2'd2
    } iommu_fault_e;

    // Bit positions inside the 2-bit {W,R} permission field
    localparam int unsigned PERM_R = 0;
    localparam int unsigned PERM_W = 1;

    // Default physical address width used by the generic response record
    localparam int unsigned IOMMU_PA_W = 64;

    typedef struct packed {
        logic [IOMMU_PA_W-1:0] pa;
        logic                  fault;
        iommu_fault_e          code;
    } iommu_rsp_t;

    // True when the permission field allows the requested access direction
    function automatic logic perm_ok(input logic [1:0] perm, input logic write);
        return write ? perm[PERM_W] : perm[PERM_R];
    endfunction

endpackage

// File: rtl/iommu_rsp_fifo.sv
// In-order valid/ready FIFO for translation responses. The element type is a
// type parameter so the top can size the physical address field. When empty
// the read port presents all-zero data so idle outputs are well defined.
module iommu_rsp_fifo
    import iommu_pkg::*;
#(
    parameter type         T     = iommu_rsp_t,
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid_i,
    output logic push_ready_o,
    input  T     push_data_i,
    output logic pop_valid_o,
    input  logic pop_ready_i,
    output T     pop_data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on the count only: a full FIFO does not accept even if popping
    assign push_ready_o = (cnt_q < CNT_W'(DEPTH));
    assign pop_valid_o  = (cnt_q != '0);
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_valid_o && pop_ready_i;

    // Head element, forced to zero while empty
    always_comb begin
        pop_data_o = '0;
        if (pop_valid_o) begin
            pop_data_o = mem_q[rd_ptr_q];
        end
    end

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is data only and needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/iommu_xlate.sv
// IOVA->PA translation against a small fully associative, software-programmed
// page table with {W,R} permission checks and an in-order response queue.
// Bypass mode returns the identity mapping without touching the table.
// Optional fault log is compiled in when IOMMU_FAULT_LOG_EN is defined.
module iommu_xlate
    import iommu_pkg::*;
#(
    parameter int unsigned IOVA_W     = 64,
    parameter int unsigned PA_W       = 64,
    parameter int unsigned PAGE_SHIFT = 12,
    parameter int unsigned ENTRIES    = 8,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            cfg_bypass,
    input  logic                                            cfg_wr_valid,
    input  logic [((ENTRIES > 1) ? $clog2(ENTRIES) : 1)-1:0] cfg_wr_idx,
    input  logic                                            cfg_wr_vld,
    input  logic [1:0]                                      cfg_wr_perm,
    input  logic [IOVA_W-PAGE_SHIFT-1:0]                    cfg_wr_vpn,
    input  logic [PA_W-PAGE_SHIFT-1:0]                      cfg_wr_ppn,
    input  logic                                            req_valid,
    input  logic [IOVA_W-1:0]                               req_iova,
    input  logic                                            req_write,
    output logic                                            req_ready,
    output logic                                            rsp_valid,
    output logic [PA_W-1:0]                                 rsp_pa,
    output logic                                            rsp_fault,
    output logic [1:0]                                      rsp_code,
`ifdef IOMMU_FAULT_LOG_EN
    output logic                                            fault_log_valid,
    output logic [IOVA_W-1:0]                               fault_log_iova,
    output logic [1:0]                                      fault_log_code,
    input  logic                                            fault_log_clr,
`endif
    input  logic                                            rsp_ready
);

    localparam int unsigned VPN_W = IOVA_W - PAGE_SHIFT;
    localparam int unsigned PPN_W = PA_W - PAGE_SHIFT;

    typedef struct packed {
        logic [PA_W-1:0] pa;
        logic            fault;
        iommu_fault_e    code;
    } rsp_t;

    logic             ent_vld_q  [ENTRIES];
    logic [1:0]       ent_perm_q [ENTRIES];
    logic [VPN_W-1:0] ent_vpn_q  [ENTRIES];
    logic [PPN_W-1:0] ent_ppn_q  [ENTRIES];

    logic             hit;
    logic [1:0]       hit_perm;
    logic [PPN_W-1:0] hit_ppn;
    rsp_t             lk_rsp;
    rsp_t             head_rsp;
    logic             accept;

    assign accept = req_valid && req_ready;

    // Entry valid bits are control state and clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ent_vld_q[i] <= 1'b0;
        end else if (cfg_wr_valid && (32'(cfg_wr_idx) < ENTRIES)) begin
            ent_vld_q[cfg_wr_idx] <= cfg_wr_vld;
        end
    end

    // Entry payload; a write replaces every field of the addressed entry
    always_ff @(posedge clk) begin
        if (cfg_wr_valid && (32'(cfg_wr_idx) < ENTRIES)) begin
            ent_perm_q[cfg_wr_idx] <= cfg_wr_perm;
            ent_vpn_q[cfg_wr_idx]  <= cfg_wr_vpn;
            ent_ppn_q[cfg_wr_idx]  <= cfg_wr_ppn;
        end
    end

    // Combinational lookup against registered table; lowest matching index wins
    always_comb begin
        hit      = 1'b0;
        hit_perm = '0;
        hit_ppn  = '0;
        lk_rsp   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && ent_vld_q[i] && (ent_vpn_q[i] == req_iova[IOVA_W-1:PAGE_SHIFT])) begin
                hit      = 1'b1;
                hit_perm = ent_perm_q[i];
                hit_ppn  = ent_ppn_q[i];
            end
        end
        if (cfg_bypass) begin
            lk_rsp.pa = req_iova[PA_W-1:0];
        end else if (!hit) begin
            lk_rsp.fault = 1'b1;
            lk_rsp.code  = IOMMU_FAULT_MISS;
        end else if (!perm_ok(hit_perm, req_write)) begin
            lk_rsp.fault = 1'b1;
            lk_rsp.code  = IOMMU_FAULT_PERM;
        end else begin
            lk_rsp.pa = {hit_ppn, req_iova[PAGE_SHIFT-1:0]};
        end
    end

    iommu_rsp_fifo #(
        .T     (rsp_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (req_valid),
        .push_ready_o (req_ready),
        .push_data_i  (lk_rsp),
        .pop_valid_o  (rsp_valid),
        .pop_ready_i  (rsp_ready),
        .pop_data_o   (head_rsp)
    );

    assign rsp_pa    = head_rsp.pa;
    assign rsp_fault = head_rsp.fault;
    assign rsp_code  = head_rsp.code;

`ifdef IOMMU_FAULT_LOG_EN
    logic              flog_vld_q,  flog_vld_d;
    logic [IOVA_W-1:0] flog_iova_q, flog_iova_d;
    logic [1:0]        flog_code_q, flog_code_d;

    // Capture the first fault; a clear in the same cycle as a new fault keeps the new one
    always_comb begin
        flog_vld_d  = flog_vld_q;
        flog_iova_d = flog_iova_q;
        flog_code_d = flog_code_q;
        if (accept && lk_rsp.fault && (!flog_vld_q || fault_log_clr)) begin
            flog_vld_d  = 1'b1;
            flog_iova_d = req_iova;
            flog_code_d = lk_rsp.code;
        end else if (fault_log_clr) begin
            flog_vld_d = 1'b0;
        end
    end

    // Fault log registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flog_vld_q  <= 1'b0;
            flog_iova_q <= '0;
            flog_code_q <= '0;
        end else begin
            flog_vld_q  <= flog_vld_d;
            flog_iova_q <= flog_iova_d;
            flog_code_q <= flog_code_d;
        end
    end

    assign fault_log_valid = flog_vld_q;
    assign fault_log_iova  = flog_iova_q;
    assign fault_log_code  = flog_code_q;
`endif

endmodule

// File: tb/tb_iommu_xlate.sv
// Self-checking bench for iommu_xlate with a behavioural page-table model.
module tb_iommu_xlate;

    localparam int IOVA_W     = 64;
    localparam int PA_W       = 64;
    localparam int PAGE_SHIFT = 12;
    localparam int ENTRIES    = 8;
    localparam int RSP_DEPTH  = 2;

    typedef struct packed {
        logic [63:0] pa;
        logic        fault;
        logic [1:0]  code;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cfg_bypass;
    logic        cfg_wr_valid;
    logic [2:0]  cfg_wr_idx;
    logic        cfg_wr_vld;
    logic [1:0]  cfg_wr_perm;
    logic [51:0] cfg_wr_vpn;
    logic [51:0] cfg_wr_ppn;
    logic        req_valid;
    logic [63:0] req_iova;
    logic        req_write;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_pa;
    logic        rsp_fault;
    logic [1:0]  rsp_code;
    logic        rsp_ready;
`ifdef IOMMU_FAULT_LOG_EN
    logic        fault_log_valid;
    logic [63:0] fault_log_iova;
    logic [1:0]  fault_log_code;
    logic        fault_log_clr;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit          m_vld  [ENTRIES];
    logic [1:0]  m_perm [ENTRIES];
    logic [63:0] m_vpn  [ENTRIES];
    logic [63:0] m_ppn  [ENTRIES];
    exp_t        exp_q [$];

    iommu_xlate #(
        .IOVA_W(IOVA_W), .PA_W(PA_W), .PAGE_SHIFT(PAGE_SHIFT),
        .ENTRIES(ENTRIES), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_bypass(cfg_bypass),
        .cfg_wr_valid(cfg_wr_valid), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_vld(cfg_wr_vld),
        .cfg_wr_perm(cfg_wr_perm), .cfg_wr_vpn(cfg_wr_vpn), .cfg_wr_ppn(cfg_wr_ppn),
        .req_valid(req_valid), .req_iova(req_iova), .req_write(req_write),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_pa(rsp_pa),
        .rsp_fault(rsp_fault), .rsp_code(rsp_code),
`ifdef IOMMU_FAULT_LOG_EN
        .fault_log_valid(fault_log_valid), .fault_log_iova(fault_log_iova),
        .fault_log_code(fault_log_code), .fault_log_clr(fault_log_clr),
`endif
        .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Translation by rule: first matching valid entry decides, else miss
    function automatic exp_t ref_xlate(logic [63:0] iova, logic wr, logic byp);
        exp_t e;
        e = '0;
        if (byp) begin
            e.pa = iova;
            return e;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_vld[i] && m_vpn[i] == (iova >> PAGE_SHIFT)) begin
                if ((wr && !m_perm[i][1]) || (!wr && !m_perm[i][0])) begin
                    e.fault = 1'b1;
                    e.code  = 2'd2;
                end else begin
                    e.pa = (m_ppn[i] << PAGE_SHIFT) | (iova % (64'd1 << PAGE_SHIFT));
                end
                return e;
            end
        end
        e.fault = 1'b1;
        e.code  = 2'd1;
        return e;
    endfunction

    // Called at a negedge; the write is visible to requests from the next cycle
    task automatic cfg_write(input int idx, input bit vld, input logic [1:0] perm,
                             input logic [63:0] vpn, input logic [63:0] ppn);
        cfg_wr_valid = 1'b1;
        cfg_wr_idx   = 3'(idx);
        cfg_wr_vld   = vld;
        cfg_wr_perm  = perm;
        cfg_wr_vpn   = vpn[51:0];
        cfg_wr_ppn   = ppn[51:0];
        @(negedge clk);
        cfg_wr_valid = 1'b0;
        m_vld[idx]  = vld;
        m_perm[idx] = perm;
        m_vpn[idx]  = vpn;
        m_ppn[idx]  = ppn;
    endtask

    // Present one request until accepted; records the model's expectation
    task automatic send(input logic [63:0] iova, input bit wr);
        int t = 0;
        req_valid = 1'b1;
        req_iova  = iova;
        req_write = wr;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_total++;
            $display("FAIL send_timeout iova=%h req_ready stuck at 0, required 1", iova);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(ref_xlate(iova, wr, cfg_bypass));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for a response, capture it, then consume it with a one-cycle ready pulse
    task automatic get_rsp(output exp_t r, output bit ok);
        int t = 0;
        r  = '0;
        ok = 1'b0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            n_total++;
            $display("FAIL rsp_timeout rsp_valid stuck at 0, required 1");
            return;
        end
        ok      = 1'b1;
        r.pa    = rsp_pa;
        r.fault = rsp_fault;
        r.code  = rsp_code;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_bypass = 0; cfg_wr_valid = 0; cfg_wr_idx = 0; cfg_wr_vld = 0;
        cfg_wr_perm = 0; cfg_wr_vpn = 0; cfg_wr_ppn = 0;
        req_valid = 0; req_iova = 0; req_write = 0; rsp_ready = 0;
`ifdef IOMMU_FAULT_LOG_EN
        fault_log_clr = 0;
`endif
        for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_pa, rsp_fault, rsp_code} !== 67'd0)
            $display("FAIL reset_outputs got v=%b pa=%h f=%b c=%0d, required all zero",
                     rsp_valid, rsp_pa, rsp_fault, rsp_code);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b required 1", req_ready);
        else n_pass++;
`ifdef IOMMU_FAULT_LOG_EN
        n_total++;
        if ({fault_log_valid, fault_log_iova, fault_log_code} !== 67'd0)
            $display("FAIL reset_flog got v=%b iova=%h c=%0d required zero",
                     fault_log_valid, fault_log_iova, fault_log_code);
        else n_pass++;
`endif
    endtask

    task automatic test_miss();
        exp_t r, e;
        bit ok;
        send(64'h1234, 1'b0);
        n_total++;
        if (rsp_valid !== 1'b1) $display("FAIL miss_latency rsp_valid=%b required 1", rsp_valid);
        else n_pass++;
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'd0, 1'b1, 2'd1} || r !== e)
                $display("FAIL miss_rsp got %h required %h", r, {64'd0, 1'b1, 2'd1});
            else n_pass++;
        end
    endtask

    task automatic test_perm();
        exp_t r, e;
        bit ok;
        cfg_write(0, 1, 2'b01, 64'h5, 64'hABC);
        send(64'h5678, 1'b0);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'hABC678, 1'b0, 2'd0} || r !== e)
                $display("FAIL perm_read got %h required %h", r, {64'hABC678, 1'b0, 2'd0});
            else n_pass++;
        end
        send(64'h5678, 1'b1);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'd0, 1'b1, 2'd2} || r !== e)
                $display("FAIL perm_write got %h required %h", r, {64'd0, 1'b1, 2'd2});
            else n_pass++;
        end
    endtask

    task automatic test_multi_hit();
        exp_t r, e;
        bit ok;
        cfg_write(2, 1, 2'b11, 64'h7, 64'h22);
        cfg_write(5, 1, 2'b11, 64'h7, 64'h55);
        send(64'h7010, 1'b0);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'h22010, 1'b0, 2'd0} || r !== e)
                $display("FAIL multi_hit got %h required %h", r, {64'h22010, 1'b0, 2'd0});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t r, e;
        logic [66:0] snap;
        bit ok;
        send(64'h5000, 1'b0);
        send(64'h7FFF, 1'b1);
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL full_req_ready got %b required 0", req_ready);
        else n_pass++;
        snap = {rsp_pa, rsp_fault, rsp_code};
        req_valid = 1'b1;
        req_iova  = 64'h9000;
        req_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (rsp_valid !== 1'b1 || {rsp_pa, rsp_fault, rsp_code} !== snap || req_ready !== 1'b0)
                $display("FAIL stall_stable cyc=%0d got v=%b rsp=%h rdy=%b required v=1 rsp=%h rdy=0",
                         i, rsp_valid, {rsp_pa, rsp_fault, rsp_code}, req_ready, snap);
            else n_pass++;
        end
        req_valid = 1'b0;
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'hABC000, 1'b0, 2'd0} || r !== e)
                $display("FAIL order_0 got %h required %h", r, {64'hABC000, 1'b0, 2'd0});
            else n_pass++;
        end
        send(64'h9000, 1'b0);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'h22FFF, 1'b0, 2'd0} || r !== e)
                $display("FAIL order_1 got %h required %h", r, {64'h22FFF, 1'b0, 2'd0});
            else n_pass++;
        end
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'd0, 1'b1, 2'd1} || r !== e)
                $display("FAIL order_2 got %h required %h", r, {64'd0, 1'b1, 2'd1});
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        exp_t r, e;
        bit ok;
        cfg_bypass = 1'b1;
        send(64'hDEAD_BEEF_0000_1000, 1'b1);
        cfg_bypass = 1'b0;
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'hDEAD_BEEF_0000_1000, 1'b0, 2'd0} || r !== e)
                $display("FAIL bypass got %h required %h", r, {64'hDEAD_BEEF_0000_1000, 1'b0, 2'd0});
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle_cfg();
        exp_t r, e;
        bit ok;
        e = ref_xlate(64'h5678, 1'b0, 1'b0);
        cfg_wr_valid = 1'b1;
        cfg_wr_idx = 3'd0; cfg_wr_vld = 1'b1; cfg_wr_perm = 2'b11;
        cfg_wr_vpn = 52'h5; cfg_wr_ppn = 52'h111;
        req_valid = 1'b1; req_iova = 64'h5678; req_write = 1'b0;
        @(negedge clk);
        cfg_wr_valid = 1'b0;
        req_valid = 1'b0;
        m_vld[0] = 1; m_perm[0] = 2'b11; m_vpn[0] = 64'h5; m_ppn[0] = 64'h111;
        get_rsp(r, ok);
        if (ok) begin
            n_total++;
            if (r !== {64'hABC678, 1'b0, 2'd0} || r !== e)
                $display("FAIL same_cycle_old got %h required %h", r, {64'hABC678, 1'b0, 2'd0});
            else n_pass++;
        end
        send(64'h5678, 1'b1);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            n_total++;
            if (r !== {64'h111678, 1'b0, 2'd0} || r !== e)
                $display("FAIL same_cycle_new got %h required %h", r, {64'h111678, 1'b0, 2'd0});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        exp_t r, e;
        bit ok;
        int n;
        logic [63:0] iova;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_write(int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                          2'($urandom_range(0, 3)), 64'($urandom_range(0, 9)), 64'($urandom));
            end else begin
                n = int'($urandom_range(1, RSP_DEPTH));
                cfg_bypass = ($urandom_range(0, 7) == 0);
                for (int k = 0; k < n; k++) begin
                    iova = (64'($urandom_range(0, 9)) << PAGE_SHIFT) | 64'($urandom_range(0, 4095));
                    if (cfg_bypass) iova = iova | {32'($urandom), 32'h0};
                    send(iova, 1'($urandom_range(0, 1)));
                end
                cfg_bypass = 1'b0;
                for (int k = 0; k < n; k++) begin
                    get_rsp(r, ok);
                    e = exp_q.pop_front();
                    if (ok) begin
                        n_total++;
                        if (r !== e) $display("FAIL random it=%0d got %h required %h", it, r, e);
                        else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midqueue();
        send(64'h5000, 1'b0);
        send(64'h6000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_pa !== 64'd0)
            $display("FAIL midq_reset got v=%b pa=%h required v=0 pa=0", rsp_valid, rsp_pa);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
        @(negedge clk);
        n_total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL midq_after got v=%b rdy=%b required v=0 rdy=1", rsp_valid, req_ready);
        else n_pass++;
    endtask

`ifdef IOMMU_FAULT_LOG_EN
    task automatic test_fault_log();
        exp_t r, e;
        bit ok;
        send(64'h1000, 1'b0);
        send(64'h2000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            get_rsp(r, ok);
            e = exp_q.pop_front();
            if (ok) begin
                n_total++;
                if (r !== e) $display("FAIL flog_rsp k=%0d got %h required %h", k, r, e);
                else n_pass++;
            end
        end
        n_total++;
        if ({fault_log_valid, fault_log_iova, fault_log_code} !== {1'b1, 64'h1000, 2'd1})
            $display("FAIL flog_first got v=%b iova=%h c=%0d required v=1 iova=1000 c=1",
                     fault_log_valid, fault_log_iova, fault_log_code);
        else n_pass++;
        fault_log_clr = 1'b1;
        @(negedge clk);
        fault_log_clr = 1'b0;
        n_total++;
        if (fault_log_valid !== 1'b0) $display("FAIL flog_clr got v=%b required 0", fault_log_valid);
        else n_pass++;
        send(64'h3000, 1'b1);
        get_rsp(r, ok);
        void'(exp_q.pop_front());
        n_total++;
        if ({fault_log_valid, fault_log_iova, fault_log_code} !== {1'b1, 64'h3000, 2'd1})
            $display("FAIL flog_next got v=%b iova=%h c=%0d required v=1 iova=3000 c=1",
                     fault_log_valid, fault_log_iova, fault_log_code);
        else n_pass++;
        fault_log_clr = 1'b1;
        send(64'h4000, 1'b0);
        fault_log_clr = 1'b0;
        get_rsp(r, ok);
        void'(exp_q.pop_front());
        n_total++;
        if ({fault_log_valid, fault_log_iova} !== {1'b1, 64'h4000})
            $display("FAIL flog_clr_and_fault got v=%b iova=%h required v=1 iova=4000",
                     fault_log_valid, fault_log_iova);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_miss();
        test_perm();
        test_multi_hit();
        test_back_to_back();
        test_bypass();
        test_same_cycle_cfg();
        test_random();
        test_reset_midqueue();
`ifdef IOMMU_FAULT_LOG_EN
        test_fault_log();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iommu_xlate.md
Name: iommu_xlate

Overview:
- Parametrised successor to the single-slot pass-through IOMMU hook in the eZ90 P7 scaffold.
- Performs real IOVA->PA translation against a small, software-programmed, fully associative page table.
- Enforces read/write permissions and queues up to RSP_DEPTH in-order responses.
- Sits between DMA-capable masters and the fabric; a bypass mode keeps identity mapping for bring-up.

Parameters:
IOVA_W, 64, request address width
PA_W, 64, physical address width (IOVA_W >= PA_W; PA_W >= PAGE_SHIFT + 1)
PAGE_SHIFT, 12, page offset bits; VPN = IOVA_W-PAGE_SHIFT, PPN = PA_W-PAGE_SHIFT
ENTRIES, 8, table entries (>=1)
RSP_DEPTH, 2, response FIFO depth (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cfg_bypass  in  1  1 = identity map, no checks
cfg_wr_valid  in  1  table write strobe
cfg_wr_idx  in  $clog2(ENTRIES) (min 1)  entry index
cfg_wr_vld  in  1  entry valid bit
cfg_wr_perm  in  2  {W,R} permission
cfg_wr_vpn  in  IOVA_W-PAGE_SHIFT  virtual page number
cfg_wr_ppn  in  PA_W-PAGE_SHIFT  physical page number
req_valid  in  1  request valid
req_iova  in  IOVA_W  request address
req_write  in  1  1 = write access
req_ready  out  1  request accepted when valid&&ready
rsp_valid  out  1  response valid
rsp_pa  out  PA_W  translated address
rsp_fault  out  1  translation faulted
rsp_code  out  2  fault code
rsp_ready  in  1  response consumed when valid&&ready

Behaviour:
- Clock/reset: one clock `clk`; `rst_n` is asynchronous, active-low.
- Reset:
  - All entry valid bits = 0; FIFO empty.
  - rsp_valid = 0, rsp_pa = 0, rsp_fault = 0, rsp_code = NONE.
  - req_ready = 1 once reset is released.
  - Reset mid-operation drops all queued responses.
- req_ready = (fifo_count < RSP_DEPTH). It is combinational from the count only; no pop-to-push pass-through when full.
- Lookup is combinational on accept; the result is pushed into the FIFO.
  - rsp_valid rises the cycle after accept if the FIFO was empty (1-cycle latency).
  - Responses are returned in order.
- Hit rule: entry valid && vpn == req_iova[IOVA_W-1:PAGE_SHIFT].
  - Multiple hits: lowest index wins.
- Miss: fault = 1, code = MISS (1), pa = 0.
- Permission check: hit with req_write && !W, or !req_write && !R, gives fault = 1, code = PERM (2), pa = 0.
- Success: pa = {ppn, req_iova[PAGE_SHIFT-1:0]}, fault = 0, code = NONE (0).
- Bypass: pa = req_iova[PA_W-1:0], fault = 0, code = NONE; no table access.
  - cfg_bypass is sampled at accept.
- Table writes:
  - A cfg write takes effect the next cycle; a request accepted in the same cycle sees the old contents.
  - A write to an index overwrites all fields.
- FIFO:
  - Simultaneous push and pop while non-empty keeps the count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_* outputs are held stable while rsp_valid && !rsp_ready.

Optional Feature:
IOMMU_FAULT_LOG_EN
- Defined: adds ports fault_log_valid (out 1), fault_log_iova (out IOVA_W), fault_log_code (out 2) and fault_log_clr (in 1).
  - The first faulting accepted request latches its iova and code and sets sticky valid.
  - Later faults are ignored until fault_log_clr is asserted.
  - A clear and a new fault in the same cycle: the new fault is captured.
  - All log state resets to 0.
- Undefined: ports absent; no log state.

Decomposition:
- Package iommu_pkg:
  - fault code enum (IOMMU_FAULT_NONE=0, IOMMU_FAULT_MISS=1, IOMMU_FAULT_PERM=2).
  - perm bit constants (PERM_R=0, PERM_W=1).
  - Response struct {pa, fault, code} parametrised via localparam widths.
- One sub-module, iommu_rsp_fifo: generic valid/ready FIFO of that struct, depth RSP_DEPTH.

Test Plan:
- Reset, no cfg, bypass=0; request iova 0x1234 -> rsp next cycle, fault=1, code=1, pa=0.
- Program idx0 vpn=0x5 ppn=0xABC perm=R; read 0x5678 -> pa=0xABC678, fault=0. Write to the same address -> fault=1, code=2.
- Program idx2 and idx5 both with vpn=0x7 (ppn 0x22 / 0x55); read 0x7010 -> pa=0x22010.
- rsp_ready=0, issue 3 requests with RSP_DEPTH=2 -> req_ready=0 after 2 accepts. Release rsp_ready -> 3 responses in order, outputs stable while stalled.
- Bypass=1, iova 0xDEAD_BEEF_0000_1000 -> pa identical, fault=0. Same-cycle cfg write plus request -> request uses the old entry.
- With IOMMU_FAULT_LOG_EN: two misses (0x1000, 0x2000) -> log holds 0x1000, code 1. Pulse clr -> valid=0. Next miss is captured. Assert rst_n low mid-queue -> rsp_valid=0 immediately.
